// File: rtl/nios_irq_ctrl_if.sv
// Avalon-MM slave bus for the Nios interrupt aggregator: 3-bit word address, 16-bit data,
// registered read data with one cycle of latency.
interface nios_irq_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_irq_ctrl.sv
// Interrupt aggregator: per-source synchronizer, level/edge mode, enable mask, sticky W1C
// pending, and a combined CPU interrupt plus priority vector (bit 0 is highest priority).
module nios_irq_ctrl #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    nios_irq_ctrl_if.slave     bus,
    output logic               irq
);

    localparam logic [2:0] AddrPending = 3'd0;
    localparam logic [2:0] AddrEnable  = 3'd1;
    localparam logic [2:0] AddrMode    = 3'd2;
    localparam logic [2:0] AddrRaw     = 3'd3;
    localparam logic [2:0] AddrVector  = 3'd4;
    localparam logic [2:0] AddrForce   = 3'd5;

    logic [NUM_IRQ-1:0] raw;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] spend_q, spend_d;
    logic [NUM_IRQ-1:0] eff_pend;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] wdata;
    logic               irq_q;
    logic               vec_valid_q;
    logic [3:0]         vec_index_q, vec_index_d;
    logic [15:0]        readdata_q, readdata_d;
    logic               wr, wr_pending, wr_enable, wr_mode, wr_force;
    logic               unused_writedata;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign raw = irq_in;
        end else begin : g_sync
            logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= irq_in;
                    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end

            assign raw = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign wdata            = bus.writedata[NUM_IRQ-1:0];
    assign unused_writedata = ^bus.writedata;

    assign wr         = bus.chipselect & ~bus.write_n;
    assign wr_pending = wr && (bus.address == AddrPending);
    assign wr_enable  = wr && (bus.address == AddrEnable);
    assign wr_mode    = wr && (bus.address == AddrMode);
    assign wr_force   = wr && (bus.address == AddrForce);

    assign edge_det = raw & ~prev_q;
    assign eff_pend = (mode_q & spend_q) | (~mode_q & raw);
    assign active   = eff_pend & enable_q;

    always_comb begin
        enable_d = wr_enable ? wdata : enable_q;
        mode_d   = wr_mode ? wdata : mode_q;
        spend_d  = spend_q;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!mode_q[i] || (wr_mode && !wdata[i])) begin
                // Leaving (or not in) edge mode drops any stored event.
                spend_d[i] = 1'b0;
            end else if (edge_det[i] || (wr_force && wdata[i])) begin
                spend_d[i] = 1'b1;
            end else if (wr_pending && wdata[i]) begin
                spend_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        vec_index_d = 4'd0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (active[i]) vec_index_d = 4'(i);
        end
    end

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            AddrPending: readdata_d[NUM_IRQ-1:0] = eff_pend;
            AddrEnable:  readdata_d[NUM_IRQ-1:0] = enable_q;
            AddrMode:    readdata_d[NUM_IRQ-1:0] = mode_q;
            AddrRaw:     readdata_d[NUM_IRQ-1:0] = raw;
            AddrVector:  readdata_d = {vec_valid_q, 11'b0, vec_index_q};
            default:     readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q      <= '0;
            enable_q    <= '0;
            mode_q      <= '0;
            spend_q     <= '0;
            irq_q       <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_index_q <= 4'd0;
            readdata_q  <= '0;
        end else begin
            prev_q      <= raw;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            spend_q     <= spend_d;
            irq_q       <= |active;
            vec_valid_q <= |active;
            vec_index_q <= vec_index_d;
            readdata_q  <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_nios_irq_ctrl.sv
// Self-checking bench for nios_irq_ctrl: register reads are scored against a queue of
// expected values filled when each read is issued.
module tb_nios_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] irq_in = '0;
    logic       irq;

    nios_irq_ctrl_if bus();

    nios_irq_ctrl #(
        .NUM_IRQ    (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .irq_in (irq_in),
        .bus    (bus),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    string       tag_q[$];
    logic [15:0] exp_q[$];
    logic        rd_req = 1'b0;
    logic        rd_vld_q = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Read data is registered, so it is compared one edge after the address was sampled.
    always @(posedge clk) rd_vld_q <= rd_req;

    always @(negedge clk) begin
        if (rd_vld_q) begin
            if (exp_q.size() == 0) check("sb_underflow", 16'd1, 16'd0);
            else check(tag_q.pop_front(), bus.readdata, exp_q.pop_front());
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] addr, input logic [15:0] exp, input string tag);
        bus.address = addr;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.address    = '0;
        bus.writedata  = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        #12;
        check("reset_irq", {15'd0, irq}, 16'd0);
        check("reset_readdata", bus.readdata, 16'd0);
        reset_n = 1'b1;
        tick(2);

        // Edge mode on source 0: pulse sampled at edge k, irq at k+3.
        wr(3'd2, 16'h0001);
        wr(3'd1, 16'h0001);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        tick(2);
        check("edge_irq_k2", {15'd0, irq}, 16'd0);
        tick();
        check("edge_irq_k3", {15'd0, irq}, 16'd1);
        rd(3'd0, 16'h0001, "edge_pending");
        rd(3'd4, 16'h8000, "edge_vector");
        wr(3'd0, 16'h0001);
        check("w1c_irq_w", {15'd0, irq}, 16'd1);
        tick();
        check("w1c_irq_w1", {15'd0, irq}, 16'd0);

        // Level mode on source 3.
        wr(3'd1, 16'h0008);
        irq_in[3] = 1'b1;
        tick(4);
        check("level_irq", {15'd0, irq}, 16'd1);
        rd(3'd4, 16'h8003, "level_vector");
        wr(3'd0, 16'h0008);
        tick(2);
        check("level_w1c_irq", {15'd0, irq}, 16'd1);
        irq_in[3] = 1'b0;
        tick(2);
        check("level_drop_k1", {15'd0, irq}, 16'd1);
        tick();
        check("level_drop_k2", {15'd0, irq}, 16'd0);

        // Priority between sources 2 and 5.
        wr(3'd2, 16'h0024);
        wr(3'd5, 16'h0024);
        wr(3'd1, 16'h0024);
        tick();
        rd(3'd4, 16'h8002, "prio_vec_2");
        wr(3'd0, 16'h0004);
        tick();
        rd(3'd4, 16'h8005, "prio_vec_5");
        wr(3'd1, 16'h0004);
        tick();
        rd(3'd4, 16'h0000, "prio_vec_none");
        check("prio_irq_off", {15'd0, irq}, 16'd0);
        rd(3'd0, 16'h0020, "disable_keeps_pend");
        wr(3'd1, 16'h0020);
        check("reenable_w", {15'd0, irq}, 16'd0);
        tick();
        check("reenable_w1", {15'd0, irq}, 16'd1);
        wr(3'd0, 16'h0020);

        // Set beats clear: W1C of bit 1 lands on the same edge as edge[1].
        wr(3'd2, 16'h0002);
        irq_in[1] = 1'b1;
        tick(2);
        wr(3'd0, 16'h0002);
        rd(3'd0, 16'h0002, "set_beats_clear");
        irq_in[1] = 1'b0;
        wr(3'd0, 16'h0002);
        rd(3'd0, 16'h0000, "clear_after_set");

        // FORCE and mode change.
        wr(3'd2, 16'h0082);
        wr(3'd5, 16'h0080);
        rd(3'd0, 16'h0080, "force_edge");
        wr(3'd2, 16'h0002);
        rd(3'd0, 16'h0000, "mode_clear");
        wr(3'd5, 16'h0010);
        rd(3'd0, 16'h0000, "force_level");
        rd(3'd5, 16'h0000, "force_reads0");

        // Bits above NUM_IRQ, RAW register and unmapped address.
        wr(3'd1, 16'hFF00);
        rd(3'd1, 16'h0000, "enable_upper");
        irq_in = 8'h05;
        tick(2);
        rd(3'd3, 16'h0005, "raw_read");
        rd(3'd6, 16'h0000, "addr6");
        irq_in = 8'h00;
        tick(3);

        // Asynchronous reset while programmed and interrupting.
        wr(3'd2, 16'h0001);
        wr(3'd1, 16'h0001);
        wr(3'd5, 16'h0001);
        bus.address = 3'd1;
        tick(2);
        check("pre_reset_irq", {15'd0, irq}, 16'd1);
        check("pre_reset_rdata", bus.readdata, 16'h0001);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_irq", {15'd0, irq}, 16'd0);
        check("async_readdata", bus.readdata, 16'd0);
        tick(2);
        reset_n = 1'b1;
        tick();
        rd(3'd1, 16'h0000, "post_reset_enable");
        rd(3'd2, 16'h0000, "post_reset_mode");
        rd(3'd0, 16'h0000, "post_reset_pending");
        tick(2);
        check("post_reset_irq", {15'd0, irq}, 16'd0);
        check("sb_empty", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
